// File: rtl/mmio_slot_bridge.sv
// Single-outstanding bridge from a CPU valid/ready register port to the shared MMIO slot bus.
// Optional watchdog on slot accesses is enabled by defining MMIO_TIMEOUT_EN.
module mmio_slot_bridge #(
    parameter int NUM_SLOTS      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [7:0]              req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_rdata,
    output logic [1:0]              resp_err,
    output logic [NUM_SLOTS-1:0]    slot_cs,
    output logic                    slot_read,
    output logic                    slot_write,
    output logic [3:0]              slot_addr,
    output logic [31:0]             slot_wdata,
    input  logic [NUM_SLOTS*32-1:0] slot_rd_data,
    input  logic [NUM_SLOTS-1:0]    slot_slave_error,
    input  logic [NUM_SLOTS-1:0]    slot_decode_error,
    input  logic [NUM_SLOTS-1:0]    slot_wr_done,
    input  logic [NUM_SLOTS-1:0]    slot_rd_done
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_DECODE  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t               state, next_state;
    logic                 is_write;
    logic [NUM_SLOTS-1:0] req_onehot;
    logic                 req_hit;
    logic                 sel_dec, sel_slv, sel_done;
    logic [31:0]          sel_rdata;
    logic                 timeout_hit;
    logic                 access_end;
    logic [1:0]           access_err;

    always_comb begin
        req_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            req_onehot[i] = (req_addr[7:4] == 4'(i));
    end

    assign req_hit = |req_onehot;

    // slot_cs is zero outside ACCESS, so these selected-slot views are quiet elsewhere.
    assign sel_dec  = |(slot_cs & slot_decode_error);
    assign sel_slv  = |(slot_cs & slot_slave_error);
    assign sel_done = is_write ? |(slot_cs & slot_wr_done) : |(slot_cs & slot_rd_done);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (slot_cs[i]) sel_rdata = sel_rdata | slot_rd_data[32*i +: 32];
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)                 tmo_cnt <= '0;
        else if (state == IDLE)   tmo_cnt <= '0;
        else if (state == ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout_hit = (state == ACCESS) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = (TIMEOUT_CYCLES < 0);  // never true: ACCESS has no deadline
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        access_end = 1'b0;
        access_err = ERR_OK;
        if (sel_dec) begin
            access_end = 1'b1;
            access_err = ERR_DECODE;
        end else if (sel_slv) begin
            access_end = 1'b1;
            access_err = ERR_SLAVE;
        end else if (sel_done) begin
            access_end = 1'b1;
        end else if (timeout_hit) begin
            access_end = 1'b1;
            access_err = ERR_TIMEOUT;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = req_hit ? ACCESS : RESP;
            ACCESS:  if (access_end) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= next_state;
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            is_write   <= 1'b0;
            slot_cs    <= '0;
            slot_read  <= 1'b0;
            slot_write <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
        end else if (state == IDLE && req_valid) begin
            is_write   <= req_write;
            slot_addr  <= req_addr[3:0];
            slot_wdata <= req_wdata;
            slot_cs    <= req_onehot;
            slot_read  <= req_hit && !req_write;
            slot_write <= req_hit && req_write;
            resp_rdata <= '0;
            resp_err   <= req_hit ? ERR_OK : ERR_DECODE;
        end else if (state == ACCESS && access_end) begin
            slot_cs    <= '0;
            slot_read  <= 1'b0;
            slot_write <= 1'b0;
            resp_err   <= access_err;
            resp_rdata <= (access_err == ERR_OK && !is_write) ? sel_rdata : '0;
        end
    end

endmodule
